// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution controller for the RV64I pipeline.
// Decodes the branch outcome from the BrEq/BrLt comparator flags. A
// mispredict raises a registered redirect to fetch, held until accepted.
// A 2-bit bimodal history table (BHT) provides the IF-stage prediction.
// Optional feature macro: BRANCH_PERF_EN adds resolve/mispredict counters.
module branch_resolve_ctrl #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            BrUn,
  input  logic            BrEq,
  input  logic            BrLt,
  output logic            ex_hold,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush
`ifdef BRANCH_PERF_EN
  ,
  output logic [63:0]     perf_branches,
  output logic [63:0]     perf_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [1:0]        bht [BHT_ENTRIES];
  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic              cond_taken, funct3_ok, taken;
  logic              resolve, mispredict, bht_upd;
  logic [XLEN-1:0]   fix_pc;
  logic              redirect_valid_next, flush_next;
  logic [XLEN-1:0]   redirect_pc_next;
  logic              unused_if_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Only the index bits of the fetch PC take part in the lookup.
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // Prediction reads the stored counter directly; an update in the same
  // cycle becomes visible only after the edge.
  assign if_pred_taken = bht[if_idx][1];

  // Signed compares for BLT/BGE, unsigned for BLTU/BGEU.
  assign BrUn = ex_funct3[1];

  // Branch condition decode from the comparator flags.
  always_comb begin
    cond_taken = 1'b0;
    funct3_ok  = 1'b1;
    case (ex_funct3)
      3'b000:  cond_taken = BrEq;
      3'b001:  cond_taken = ~BrEq;
      3'b100:  cond_taken = BrLt;
      3'b101:  cond_taken = ~BrLt;
      3'b110:  cond_taken = BrLt;
      3'b111:  cond_taken = ~BrLt;
      default: funct3_ok  = 1'b0;
    endcase
  end

  // A jump overrides any branch decode and is always taken.
  assign taken      = ex_is_jump | (ex_is_branch & cond_taken);
  assign resolve    = ex_valid & (ex_is_branch | ex_is_jump) & (state == IDLE);
  assign mispredict = taken != ex_pred_taken;
  assign fix_pc     = taken ? ex_target : ex_pc + XLEN'(4);
  assign bht_upd    = resolve & ex_is_branch & ~ex_is_jump & funct3_ok;

  assign ex_hold    = (state == REDIRECT) & ~rst;

  // Next-state logic: raise a redirect on mispredict, hold it until fetch accepts.
  always_comb begin
    state_next          = state;
    redirect_valid_next = redirect_valid;
    redirect_pc_next    = redirect_pc;
    flush_next          = 1'b0;
    case (state)
      IDLE: begin
        if (resolve && mispredict) begin
          state_next          = REDIRECT;
          redirect_valid_next = 1'b1;
          redirect_pc_next    = fix_pc;
          flush_next          = 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_next          = IDLE;
          redirect_valid_next = 1'b0;
        end
      end
      default: begin
        state_next          = IDLE;
        redirect_valid_next = 1'b0;
      end
    endcase
  end

  // State and registered redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      state          <= state_next;
      redirect_valid <= redirect_valid_next;
      redirect_pc    <= redirect_pc_next;
      flush          <= flush_next;
    end
  end

  // Saturating 2-bit counter update on resolved conditional branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (bht_upd) begin
      if (taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  // Resolve and mispredict event counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (resolve) begin
      perf_branches <= perf_branches + 64'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: vector table plus corner sequences.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_pc, ex_target;
  logic        BrUn, BrEq, BrLt;
  logic        ex_hold, redirect_valid, redirect_ready, flush;
  logic [63:0] redirect_pc;
`ifdef BRANCH_PERF_EN
  logic [63:0] perf_branches, perf_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic last_brun, last_if_pred;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.BHT_ENTRIES(64), .XLEN(64)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .BrUn(BrUn), .BrEq(BrEq), .BrLt(BrLt),
    .ex_hold(ex_hold), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush)
`ifdef BRANCH_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic        eq, lt, br, jp, vld, pred;
    logic [63:0] pc, tgt;
    logic        exp_brun, exp_rd;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One EX cycle of stimulus, then check the redirect and complete the handshake.
  task automatic do_resolve(input string nm, input logic [2:0] f3, input logic eq,
                            input logic lt, input logic br, input logic jp,
                            input logic vld, input logic pred,
                            input logic [63:0] pc, input logic [63:0] tgt,
                            input logic exp_rd, input logic [63:0] exp_pc);
    ex_valid = vld; ex_is_branch = br; ex_is_jump = jp; ex_funct3 = f3;
    BrEq = eq; BrLt = lt; ex_pred_taken = pred; ex_pc = pc; ex_target = tgt;
    redirect_ready = 1'b0;
    #1;
    last_brun    = BrUn;
    last_if_pred = if_pred_taken;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk({nm, "_rv"}, 64'(redirect_valid), 64'(exp_rd));
    chk({nm, "_flush"}, 64'(flush), 64'(exp_rd));
    chk({nm, "_hold"}, 64'(ex_hold), 64'(exp_rd));
    if (exp_rd) begin
      chk({nm, "_rpc"}, redirect_pc, exp_pc);
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      chk({nm, "_rv_clr"}, 64'(redirect_valid), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    //            f3      eq    lt    br    jp    vld   pred  pc                      tgt           brun  rd    exp_pc
    vt[0]  = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h100,                64'h200, 1'b0, 1'b1, 64'h200};
    vt[1]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h100,                64'h200, 1'b0, 1'b0, 64'h0};
    vt[2]  = '{3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h104,                64'h300, 1'b0, 1'b1, 64'h300};
    vt[3]  = '{3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h108,                64'h380, 1'b0, 1'b0, 64'h0};
    vt[4]  = '{3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h110,                64'h400, 1'b0, 1'b1, 64'h114};
    vt[5]  = '{3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2000,               64'h2400, 1'b1, 1'b1, 64'h2400};
    vt[6]  = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h120,                64'h500, 1'b1, 1'b1, 64'h500};
    vt[7]  = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h130,                64'h600, 1'b1, 1'b1, 64'h134};
    vt[8]  = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h134,                64'h600, 1'b1, 1'b0, 64'h0};
    vt[9]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h140,                64'h700, 1'b0, 1'b1, 64'h700};
    vt[10] = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h144,                64'h740, 1'b1, 1'b0, 64'h0};
    vt[11] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h150,                64'h800, 1'b0, 1'b1, 64'h800};
    vt[12] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10,  1'b0, 1'b1, 64'h0};
    vt[13] = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h160,                64'h900, 1'b0, 1'b0, 64'h0};
    vt[14] = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h164,                64'h900, 1'b0, 1'b0, 64'h0};
    vt[15] = '{3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h168,                64'h940, 1'b1, 1'b1, 64'h16C};

    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_funct3 = 3'b000;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; BrEq = 1'b0; BrLt = 1'b0;
    redirect_ready = 1'b0; if_pc = 64'h1000;
    do_reset();

    // Reset state
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_hold", 64'(ex_hold), 64'd0);
    chk("rst_pred", 64'(if_pred_taken), 64'd0);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      do_resolve($sformatf("vec%0d", i), vt[i].f3, vt[i].eq, vt[i].lt, vt[i].br,
                 vt[i].jp, vt[i].vld, vt[i].pred, vt[i].pc, vt[i].tgt,
                 vt[i].exp_rd, vt[i].exp_pc);
      chk($sformatf("vec%0d_brun", i), 64'(last_brun), 64'(vt[i].exp_brun));
    end

    // BHT training at idx 0 (0x1000, 0x2000, 0x3000 all alias)
    do_reset();
    if_pc = 64'h1000;
    do_resolve("train1", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("no_bypass", 64'(last_if_pred), 64'd0);
    chk("train1_pred", 64'(if_pred_taken), 64'd1);
    do_resolve("train2", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("train2_pred", 64'(if_pred_taken), 64'd1);

    // Saturation at 11: taken BGE keeps 11, one decrement must still predict taken
    do_resolve("bge_sat", 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    do_resolve("dec1", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("sat_dec1_pred", 64'(if_pred_taken), 64'd1);
    do_resolve("dec2", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("sat_dec2_pred", 64'(if_pred_taken), 64'd0);

    // funct3=010 and jumps leave the counter alone
    do_resolve("inc", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("inc_pred", 64'(if_pred_taken), 64'd1);
    do_resolve("f010", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("f010_noupd", 64'(if_pred_taken), 64'd1);
    do_resolve("jmp", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    do_resolve("dec3", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("jmp_noupd", 64'(if_pred_taken), 64'd0);

    // Redirect held 3 cycles; ready in IDLE ignored; no resolve while waiting
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jump = 1'b0; ex_funct3 = 3'b110;
    BrLt = 1'b1; BrEq = 1'b0; ex_pred_taken = 1'b0; ex_pc = 64'h2000; ex_target = 64'h2400;
    redirect_ready = 1'b1;
    #1;
    chk("hold_brun", 64'(BrUn), 64'd1);
    chk("hold_idle", 64'(ex_hold), 64'd0);
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    ex_pc = 64'h3000; ex_target = 64'h3800;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wait%0d_rv", c), 64'(redirect_valid), 64'd1);
      chk($sformatf("wait%0d_flush", c), 64'(flush), (c == 0) ? 64'd1 : 64'd0);
      chk($sformatf("wait%0d_hold", c), 64'(ex_hold), 64'd1);
      chk($sformatf("wait%0d_rpc", c), redirect_pc, 64'h2400);
      if (c == 2) begin
        redirect_ready = 1'b1;
        ex_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    redirect_ready = 1'b0;
    chk("done_rv", 64'(redirect_valid), 64'd0);
    chk("done_hold", 64'(ex_hold), 64'd0);
    chk("done_flush", 64'(flush), 64'd0);
    @(posedge clk); #1;
    chk("done2_rv", 64'(redirect_valid), 64'd0);
    // Counter went 01->10 from the BLTU resolve only, not from the stalled one
    if_pc = 64'h1000;
    #1;
    chk("stall_pred", 64'(if_pred_taken), 64'd1);
    do_resolve("dec4", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("stall_noupd", 64'(if_pred_taken), 64'd0);

    // Reset in REDIRECT
    do_resolve("tr3", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    do_resolve("tr4", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b000; BrEq = 1'b1;
    ex_pred_taken = 1'b0; ex_pc = 64'h40; ex_target = 64'h80;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("pre_rst_rv", 64'(redirect_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("in_rst_hold", 64'(ex_hold), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_rv", 64'(redirect_valid), 64'd0);
    chk("post_rst_hold", 64'(ex_hold), 64'd0);
    chk("post_rst_flush", 64'(flush), 64'd0);
    chk("post_rst_rpc", redirect_pc, 64'd0);
    chk("post_rst_pred", 64'(if_pred_taken), 64'd0);
`ifdef BRANCH_PERF_EN
    chk("perf_rst_b", perf_branches, 64'd0);
    chk("perf_rst_m", perf_mispredicts, 64'd0);
`endif
    do_resolve("post_inc", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1000, 64'h1800, 1'b0, 64'h0);
    chk("post_rst_ctr01", 64'(if_pred_taken), 64'd1);

`ifdef BRANCH_PERF_EN
    do_resolve("p2", 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h500, 64'h600, 1'b0, 64'h0);
    do_resolve("p3", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h504, 64'h700, 1'b0, 64'h0);
    do_resolve("p4", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h508, 64'h800, 1'b1, 64'h800);
    do_resolve("p5", 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h50C, 64'h900, 1'b1, 64'h510);
    chk("perf_b", perf_branches, 64'd5);
    chk("perf_m", perf_mispredicts, 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
EX-stage branch controller for the RV64I pipeline. It drives the comparator's BrUn select and consumes BrEq/BrLt to resolve conditional branches and jumps. It compares each outcome with the IF-stage prediction from its internal 2-bit bimodal history table (BHT). On a mismatch it issues a registered redirect/flush to fetch, holding it until fetch accepts.

Parameters:
BHT_ENTRIES, 64, number of 2-bit counters; power of two, 4..1024
XLEN, 64, PC/target width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_pc  in  XLEN  fetch PC for prediction lookup
if_pred_taken  out  1  prediction for if_pc (combinational)
ex_valid  in  1  EX holds a valid instruction
ex_is_branch  in  1  conditional branch in EX
ex_is_jump  in  1  JAL/JALR in EX
ex_funct3  in  3  branch funct3
ex_pc  in  XLEN  EX instruction PC
ex_target  in  XLEN  computed branch/jump target
ex_pred_taken  in  1  prediction carried down the pipe
BrUn  out  1  comparator unsigned select
BrEq  in  1  comparator equal
BrLt  in  1  comparator less-than
ex_hold  out  1  stall EX (redirect pending)
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  redirect address
redirect_ready  in  1  fetch accepts redirect
flush  out  1  one-cycle pulse: kill IF/ID

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; redirect_valid=0; redirect_pc=0; flush=0; every BHT counter=2'b01 (weakly not-taken). ex_hold=0 during/after reset. Reset mid-REDIRECT discards the pending redirect.
- BrUn = ex_funct3[1], combinational, independent of ex_valid.
- Taken decode: 000 BEQ=BrEq; 001 BNE=!BrEq; 100 BLT=BrLt; 101 BGE=!BrLt; 110 BLTU=BrLt; 111 BGEU=!BrLt; 010/011 = not taken, no BHT update.
- Jump (ex_is_jump=1): always taken; never updates the BHT. ex_is_branch and ex_is_jump both set: jump wins.
- Index = pc[log2(BHT_ENTRIES)+1:2]. if_pred_taken = bht[idx(if_pc)][1].
- Resolve event = ex_valid & (ex_is_branch|ex_is_jump) & state==IDLE.
- mispredict = taken != ex_pred_taken. fix_pc = taken ? ex_target : ex_pc+4 (mod 2^XLEN; wraps at all-ones).
- FSM IDLE: resolve with mispredict -> next edge: REDIRECT, redirect_valid=1, redirect_pc=fix_pc, flush=1 for exactly that cycle. Correct prediction: stay IDLE, no outputs.
- FSM REDIRECT: redirect_valid and redirect_pc held stable; ex_hold=1; no new resolve. redirect_ready=1 -> next edge IDLE, redirect_valid=0. flush is not re-pulsed while waiting. redirect_ready sampled in IDLE is ignored.
- BHT update on the resolve edge (conditional branch, valid funct3): taken -> saturating +1 (max 11); not taken -> saturating -1 (min 00).
- Same-cycle lookup and update to the same index: if_pred_taken returns the pre-update value (no bypass); the new value is visible next cycle.
- Latency: resolve cycle N -> redirect_valid/flush at N+1; earliest IDLE return at N+2.

Optional Feature:
BRANCH_PERF_EN: defined -> adds outputs perf_branches (64) and perf_mispredicts (64). These count resolve events and mispredicting resolve events, reset to 0 and wrap at 2^64. Undefined -> ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, if_pc=0x1000 -> if_pred_taken=0; after 2 taken BEQ resolves (BrEq=1, pc=0x1000) -> if_pred_taken=1.
- BLTU funct3=110, BrLt=1, pred=0, pc=0x2000, target=0x2400 -> BrUn=1; next cycle redirect_valid=1, redirect_pc=0x2400, flush=1 for 1 cycle.
- BGE funct3=101, BrLt=0, pred=1 -> no redirect; counter 11 stays 11 (saturation).
- Mispredict with redirect_ready=0 for 3 cycles -> redirect_valid and ex_hold held 3 cycles, flush pulsed once; ready=1 -> IDLE next edge.
- Not-taken mispredict at pc=0xFFFF_FFFF_FFFF_FFFC -> redirect_pc=0x0 (wrap); funct3=010 -> not taken, BHT unchanged.
- rst asserted while in REDIRECT -> next cycle redirect_valid=0, ex_hold=0, all counters 01; with BRANCH_PERF_EN, 5 resolves/2 mispredicts -> perf counters 5/2.
